// File: rtl/xls_pipe_drain.sv
// xls_pipe_drain
// Issue/sink wrapper for a fixed-latency, valid-only pipeline with no backpressure.
// Launches are credited against a result FIFO, so every launch has a guaranteed
// slot when its result arrives. Results are returned in launch order on a
// ready/valid response port. After reset, a drain window discards stale results
// that are still in the pipeline's un-reset valid stages.
module xls_pipe_drain #(
   parameter int DATA_W  = 32,
   parameter int LATENCY = 2,
   parameter int DEPTH   = 4,
   localparam int W      = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   output logic              pipe_input_valid,
   input  logic              pipe_output_valid,
   input  logic [DATA_W-1:0] pipe_out,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_data,
   input  logic              resp_ready,
   output logic [W-1:0]      inflight,
   output logic              overflow_err
);

   // Pointer and drain-counter widths; a single-entry FIFO still needs a 1-bit pointer.
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(LATENCY + 1);

   localparam logic [W-1:0]  DEPTH_W  = W'(DEPTH);
   localparam logic [W-1:0]  ONE_W    = W'(1);
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
   localparam logic [PW-1:0] ONE_P    = PW'(1);
   localparam logic [CW-1:0] LAT_C    = CW'(LATENCY);
   localparam logic [CW-1:0] ONE_C    = CW'(1);

   typedef enum logic {
      ST_DRAIN = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_t            state_reg, state_next;
   logic [CW-1:0]     drain_cnt_reg, drain_cnt_next;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PW-1:0]     wr_ptr_reg, wr_ptr_next;
   logic [PW-1:0]     rd_ptr_reg, rd_ptr_next;
   logic [W-1:0]      count_reg, count_next;
   logic [W-1:0]      inflight_reg, inflight_next;
   logic              overflow_reg, overflow_next;
   logic [DATA_W-1:0] resp_data_reg;

   // ------------------------------------------------------------------
   // Handshake and event decode
   // ------------------------------------------------------------------
   logic              normal_mode;
   logic              fifo_full;
   logic              fifo_empty;
   logic [W:0]        occupancy;
   logic              has_credit;
   logic              launch;
   logic              push;
   logic              pop;
   logic              bad_result;
   logic              head_from_push;

   // Wrap a FIFO pointer modulo DEPTH (DEPTH need not be a power of two).
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + ONE_P;
   endfunction

   assign normal_mode = (state_reg == ST_RUN);
   assign fifo_full   = (count_reg == DEPTH_W);
   assign fifo_empty  = (count_reg == '0);

   // Every buffered or in-flight result owns one FIFO slot; a launch needs a free one.
   assign occupancy   = {1'b0, count_reg} + {1'b0, inflight_reg};
   assign has_credit  = (occupancy < {1'b0, DEPTH_W});

   // req_ready depends only on state (and reset), never on req_valid.
   assign req_ready        = !rst && normal_mode && has_credit;
   assign launch           = req_valid && req_ready;
   assign pipe_input_valid = launch;

   assign resp_valid = !rst && !fifo_empty;
   assign pop        = resp_valid && resp_ready;

   // A result is accepted only if something was launched and a slot is free;
   // anything else in normal mode is a protocol violation and is dropped.
   assign push       = normal_mode && pipe_output_valid && (inflight_reg != '0) && !fifo_full;
   assign bad_result = normal_mode && pipe_output_valid && ((inflight_reg == '0) || fifo_full);

   // The pushed word becomes the head when it lands at the slot the read pointer
   // will point to next (FIFO empty, or last entry popped in the same cycle).
   assign head_from_push = push && (wr_ptr_reg == rd_ptr_next);

   assign resp_data    = rst ? '0 : resp_data_reg;
   assign inflight     = inflight_reg;
   assign overflow_err = overflow_reg;

   // ------------------------------------------------------------------
   // Drain-window FSM: register
   // ------------------------------------------------------------------
   // Mode register; reset re-arms the drain window with LATENCY cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= ST_DRAIN;
         drain_cnt_reg <= LAT_C;
      end else begin
         state_reg     <= state_next;
         drain_cnt_reg <= drain_cnt_next;
      end
   end

   // Count the drain window down; enter normal mode as the counter reaches zero.
   always_comb begin
      state_next     = state_reg;
      drain_cnt_next = drain_cnt_reg;
      case (state_reg)
         ST_DRAIN: begin
            if (drain_cnt_reg != '0) begin
               drain_cnt_next = drain_cnt_reg - ONE_C;
            end
            if (drain_cnt_reg <= ONE_C) begin
               state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            state_next = ST_RUN;
         end
         default: begin
            state_next = ST_DRAIN;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // FIFO and credit bookkeeping
   // ------------------------------------------------------------------
   // Next-state for pointers, occupancy, in-flight count and the sticky error.
   always_comb begin
      wr_ptr_next   = wr_ptr_reg;
      rd_ptr_next   = rd_ptr_reg;
      count_next    = count_reg;
      inflight_next = inflight_reg;
      overflow_next = overflow_reg | bad_result;

      if (push) begin
         wr_ptr_next = ptr_inc(wr_ptr_reg);
      end
      if (pop) begin
         rd_ptr_next = ptr_inc(rd_ptr_reg);
      end

      case ({push, pop})
         2'b10:   count_next = count_reg + ONE_W;
         2'b01:   count_next = count_reg - ONE_W;
         default: count_next = count_reg;
      endcase

      // A returning result retires one launch; launch and retire together cancel.
      case ({launch, push})
         2'b10:   inflight_next = inflight_reg + ONE_W;
         2'b01:   inflight_next = inflight_reg - ONE_W;
         default: inflight_next = inflight_reg;
      endcase
   end

   // Bookkeeping registers; reset discards everything in flight and buffered.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         inflight_reg <= '0;
         overflow_reg <= 1'b0;
      end else begin
         wr_ptr_reg   <= wr_ptr_next;
         rd_ptr_reg   <= rd_ptr_next;
         count_reg    <= count_next;
         inflight_reg <= inflight_next;
         overflow_reg <= overflow_next;
      end
   end

   // Result storage: plain write port, no reset, so it maps onto RAM.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= pipe_out;
      end
   end

   // Registered head-of-FIFO read; bypasses the incoming word when it becomes
   // the new head, and holds the last value while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (rst) begin
         resp_data_reg <= '0;
      end else if (head_from_push) begin
         resp_data_reg <= pipe_out;
      end else if (pop && (count_next != '0)) begin
         resp_data_reg <= mem[rd_ptr_next];
      end
   end

endmodule

// File: tb/tb_xls_pipe_drain.sv
// Bench for xls_pipe_drain: directed scenarios against a 2-stage valid-only
// pipeline model that returns the launch index as its result.
module tb_xls_pipe_drain;

   localparam int DATA_W = 32;
   localparam int W      = 3;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic              pipe_input_valid;
   logic              pipe_output_valid;
   logic [DATA_W-1:0] pipe_out;
   logic              resp_valid;
   logic [DATA_W-1:0] resp_data;
   logic              resp_ready = 1'b0;
   logic [W-1:0]      inflight;
   logic              overflow_err;

   int n_checks = 0;
   int n_pass   = 0;

   // Pipeline model: valid stages are deliberately not reset.
   logic              v1 = 1'b0, v2 = 1'b0;
   logic [DATA_W-1:0] d1 = '0, d2 = '0;
   logic              force_ov = 1'b0;
   logic              tb_clr = 1'b1;
   logic [DATA_W-1:0] launch_idx = '0;

   int                n_pop = 0;
   int                cyc = 0;
   logic [DATA_W-1:0] got_q[$];
   int                pop_cyc_q[$];

   always #5 clk = ~clk;

   xls_pipe_drain #(.DATA_W(32), .LATENCY(2), .DEPTH(4)) dut (
      .clk               (clk),
      .rst               (rst),
      .req_valid         (req_valid),
      .req_ready         (req_ready),
      .pipe_input_valid  (pipe_input_valid),
      .pipe_output_valid (pipe_output_valid),
      .pipe_out          (pipe_out),
      .resp_valid        (resp_valid),
      .resp_data         (resp_data),
      .resp_ready        (resp_ready),
      .inflight          (inflight),
      .overflow_err      (overflow_err)
   );

   assign pipe_output_valid = v2 | force_ov;
   assign pipe_out          = force_ov ? 32'hDEAD_BEEF : d2;

   always @(posedge clk) begin
      v1 <= pipe_input_valid;
      d1 <= launch_idx;
      v2 <= v1;
      d2 <= d1;
      if (tb_clr) launch_idx <= '0;
      else if (pipe_input_valid) launch_idx <= launch_idx + 1;
   end

   // Response monitor: one line per popped response.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (tb_clr) begin
         n_pop <= 0;
         got_q.delete();
         pop_cyc_q.delete();
      end else if (resp_valid && resp_ready) begin
         got_q.push_back(resp_data);
         pop_cyc_q.push_back(cyc);
         n_pop <= n_pop + 1;
         $display("resp #%0d data=%0d cycle=%0d", n_pop, resp_data, cyc);
      end
   end

   // Two reset edges, then release; returns in drain cycle 1.
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; tb_clr = 1'b1; req_valid = 1'b0; resp_ready = 1'b0; force_ov = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0; tb_clr = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1; tb_clr = 1'b1; req_valid = 1'b1; resp_ready = 1'b1; force_ov = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      n_checks++; if (req_ready !== 1'b0) $display("FAIL rst_req_ready: got %0h want 0", req_ready); else n_pass++;
      n_checks++; if (pipe_input_valid !== 1'b0) $display("FAIL rst_pipe_in_valid: got %0h want 0", pipe_input_valid); else n_pass++;
      n_checks++; if (resp_valid !== 1'b0) $display("FAIL rst_resp_valid: got %0h want 0", resp_valid); else n_pass++;
      n_checks++; if (resp_data !== 32'h0) $display("FAIL rst_resp_data: got %0h want 0", resp_data); else n_pass++;
      n_checks++; if (inflight !== 3'd0) $display("FAIL rst_inflight: got %0d want 0", inflight); else n_pass++;
      n_checks++; if (overflow_err !== 1'b0) $display("FAIL rst_overflow: got %0h want 0", overflow_err); else n_pass++;
      rst = 1'b0; tb_clr = 1'b0; resp_ready = 1'b0;
      #1;
      n_checks++; if (pipe_input_valid !== 1'b0) $display("FAIL drain1_launch: got %0h want 0", pipe_input_valid); else n_pass++;
      @(negedge clk); #1;
      n_checks++; if (req_ready !== 1'b0) $display("FAIL drain2_req_ready: got %0h want 0", req_ready); else n_pass++;
      req_valid = 1'b0;
      @(negedge clk); #1;
      n_checks++; if (req_ready !== 1'b1) $display("FAIL normal_req_ready: got %0h want 1", req_ready); else n_pass++;
   endtask

   task automatic test_single();
      do_reset();
      repeat (2) @(negedge clk);
      req_valid = 1'b1; #1;
      n_checks++; if (pipe_input_valid !== 1'b1) $display("FAIL single_launch: got %0h want 1", pipe_input_valid); else n_pass++;
      @(negedge clk); req_valid = 1'b0; #1;
      n_checks++; if (inflight !== 3'd1) $display("FAIL single_inflight1: got %0d want 1", inflight); else n_pass++;
      @(negedge clk); #1;
      n_checks++; if (resp_valid !== 1'b0) $display("FAIL single_early_resp: got %0h want 0", resp_valid); else n_pass++;
      @(negedge clk); #1;
      n_checks++; if (resp_valid !== 1'b1) $display("FAIL single_resp_valid: got %0h want 1", resp_valid); else n_pass++;
      n_checks++; if (resp_data !== 32'd0) $display("FAIL single_resp_data: got %0h want 0", resp_data); else n_pass++;
      n_checks++; if (inflight !== 3'd0) $display("FAIL single_inflight0: got %0d want 0", inflight); else n_pass++;
      resp_ready = 1'b1;
      @(negedge clk); resp_ready = 1'b0; #1;
      n_checks++; if (resp_valid !== 1'b0) $display("FAIL single_popped: got %0h want 0", resp_valid); else n_pass++;
   endtask

   task automatic test_fill();
      int launches = 0;
      do_reset();
      repeat (2) @(negedge clk);
      req_valid = 1'b1;
      repeat (10) begin
         #1; if (pipe_input_valid) launches++;
         @(negedge clk);
      end
      #1;
      n_checks++; if (launches !== 4) $display("FAIL fill_launches: got %0d want 4", launches); else n_pass++;
      n_checks++; if (req_ready !== 1'b0) $display("FAIL fill_req_ready: got %0h want 0", req_ready); else n_pass++;
      n_checks++; if (inflight !== 3'd0) $display("FAIL fill_inflight: got %0d want 0", inflight); else n_pass++;
      n_checks++; if (overflow_err !== 1'b0) $display("FAIL fill_overflow: got %0h want 0", overflow_err); else n_pass++;
      req_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         n_checks++; if (resp_valid !== 1'b1 || resp_data !== 32'(k)) $display("FAIL fill_data%0d: got v=%0h d=%0d want v=1 d=%0d", k, resp_valid, resp_data, k); else n_pass++;
         resp_ready = 1'b1;
         @(negedge clk);
      end
      resp_ready = 1'b0; #1;
      n_checks++; if (resp_valid !== 1'b0) $display("FAIL fill_empty: got %0h want 0", resp_valid); else n_pass++;
   endtask

   task automatic test_stream();
      int misses = 0;
      int bad = 0;
      do_reset();
      repeat (2) @(negedge clk);
      resp_ready = 1'b1; req_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         #1; if (pipe_input_valid !== 1'b1) misses++;
         @(negedge clk);
      end
      req_valid = 1'b0;
      repeat (6) @(negedge clk);
      #1;
      n_checks++; if (misses !== 0) $display("FAIL stream_rate: got %0d missed launches want 0", misses); else n_pass++;
      n_checks++; if (got_q.size() !== 20) $display("FAIL stream_count: got %0d want 20", got_q.size()); else n_pass++;
      for (int i = 0; i < got_q.size(); i++) if (got_q[i] !== 32'(i)) bad++;
      n_checks++; if (bad !== 0) $display("FAIL stream_order: got %0d out-of-order want 0", bad); else n_pass++;
      n_checks++; if (got_q.size() != 20 || pop_cyc_q[19] - pop_cyc_q[0] !== 19) $display("FAIL stream_gaps: got span %0d want 19", (got_q.size() == 20) ? pop_cyc_q[19] - pop_cyc_q[0] : -1); else n_pass++;
      resp_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      int occ;
      int bad = 0;
      do_reset();
      repeat (2) @(negedge clk);
      req_valid = 1'b1;
      for (int i = 0; i < 30; i++) begin
         resp_ready = (i % 2) == 0;
         #1;
         occ = int'(launch_idx) - n_pop;
         n_checks++; if (req_ready !== (occ < 4) || occ > 4 || occ < 0) $display("FAIL bp_credit%0d: got ready=%0h occ=%0d want ready=%0h occ<=4", i, req_ready, occ, (occ < 4)); else n_pass++;
         @(negedge clk);
      end
      req_valid = 1'b0; resp_ready = 1'b1;
      repeat (8) @(negedge clk);
      #1;
      n_checks++; if (got_q.size() !== int'(launch_idx) || got_q.size() < 10) $display("FAIL bp_count: got %0d want %0d (>=10)", got_q.size(), launch_idx); else n_pass++;
      for (int i = 0; i < got_q.size(); i++) if (got_q[i] !== 32'(i)) bad++;
      n_checks++; if (bad !== 0) $display("FAIL bp_order: got %0d out-of-order want 0", bad); else n_pass++;
      n_checks++; if (overflow_err !== 1'b0) $display("FAIL bp_overflow: got %0h want 0", overflow_err); else n_pass++;
      resp_ready = 1'b0;
   endtask

   task automatic test_reset_midflight();
      do_reset();
      repeat (2) @(negedge clk);
      req_valid = 1'b1;
      repeat (2) begin
         #1;
         n_checks++; if (pipe_input_valid !== 1'b1) $display("FAIL mid_launch: got %0h want 1", pipe_input_valid); else n_pass++;
         @(negedge clk);
      end
      req_valid = 1'b0; rst = 1'b1; tb_clr = 1'b1;
      @(negedge clk);
      rst = 1'b0; tb_clr = 1'b0; #1;
      n_checks++; if (pipe_output_valid !== 1'b1 || req_ready !== 1'b0) $display("FAIL mid_drain: got pov=%0h ready=%0h want pov=1 ready=0", pipe_output_valid, req_ready); else n_pass++;
      @(negedge clk); #1;
      n_checks++; if (req_ready !== 1'b0) $display("FAIL mid_drain2_ready: got %0h want 0", req_ready); else n_pass++;
      repeat (3) @(negedge clk);
      #1;
      n_checks++; if (resp_valid !== 1'b0) $display("FAIL mid_resp_valid: got %0h want 0", resp_valid); else n_pass++;
      n_checks++; if (overflow_err !== 1'b0) $display("FAIL mid_overflow: got %0h want 0", overflow_err); else n_pass++;
      n_checks++; if (inflight !== 3'd0) $display("FAIL mid_inflight: got %0d want 0", inflight); else n_pass++;
      n_checks++; if (req_ready !== 1'b1) $display("FAIL mid_ready_after: got %0h want 1", req_ready); else n_pass++;
   endtask

   task automatic test_spurious();
      do_reset();
      repeat (2) @(negedge clk);
      #1;
      n_checks++; if (overflow_err !== 1'b0) $display("FAIL spur_pre: got %0h want 0", overflow_err); else n_pass++;
      force_ov = 1'b1;
      @(negedge clk);
      force_ov = 1'b0; #1;
      n_checks++; if (overflow_err !== 1'b1) $display("FAIL spur_set: got %0h want 1", overflow_err); else n_pass++;
      n_checks++; if (resp_valid !== 1'b0) $display("FAIL spur_no_push: got %0h want 0", resp_valid); else n_pass++;
      n_checks++; if (inflight !== 3'd0) $display("FAIL spur_inflight: got %0d want 0", inflight); else n_pass++;
      repeat (3) @(negedge clk);
      #1;
      n_checks++; if (overflow_err !== 1'b1) $display("FAIL spur_sticky: got %0h want 1", overflow_err); else n_pass++;
      n_checks++; if (req_ready !== 1'b1) $display("FAIL spur_credits: got %0h want 1", req_ready); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill();
      test_stream();
      test_backpressure();
      test_reset_midflight();
      test_spurious();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "timeout");
   end

endmodule
